// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole game sequencer.
// Chooses the hole the mole pops up in, times the up/gap phases with a
// tick prescaler, scores rising-edge button hits on the active hole and
// counts timeouts until the miss limit ends the game. Every output is a
// flop so the sprite renderer never sees a combinational path from the
// buttons.
module mole_scheduler #(
  parameter int NUM_HOLES  = 4,
  parameter int TICK_DIV   = 1000000,
  parameter int UP_TICKS   = 100,
  parameter int GAP_TICKS  = 50,
  parameter int MAX_MISSES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] hit_btn,
  output logic                 mole_visible,
  output logic [2:0]           mole_hole,
  output logic [9:0]           sprite_x_offset,
  output logic [9:0]           sprite_y_offset,
  output logic [7:0]           score,
  output logic [7:0]           misses,
  output logic                 game_over
);

  // Prescaler counts 0..TICK_DIV-1; tick counter counts 0..phase_ticks-1.
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [PW-1:0]        PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0]        GAP_LAST   = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0]        UP_LAST    = TW'(UP_TICKS - 1);
  localparam logic [7:0]           MISS_LIMIT = 8'(MAX_MISSES);
  localparam logic [2:0]           HOLE_MASK  = 3'(NUM_HOLES - 1);
  localparam logic [NUM_HOLES-1:0] HOLE0_SEL  = NUM_HOLES'(1);
  localparam logic [7:0]           LFSR_SEED  = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_UP   = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  // Fibonacci LFSR step for x^8 + x^6 + x^5 + x^4 + 1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Candidate hole from the LFSR, bumped by one if it repeats the last hole.
  function automatic logic [2:0] pick_hole(input logic [7:0] src, input logic [2:0] prev);
    logic [2:0] cand;
    cand = src[2:0] & HOLE_MASK;
    if (cand == prev) begin
      cand = (cand + 3'd1) & HOLE_MASK;
    end else begin
      cand = cand;
    end
    return cand;
  endfunction

  // Holes 0..3 sit on row 0, 4..7 on row 1, 128 px apart horizontally.
  function automatic logic [9:0] x_of(input logic [2:0] hole);
    return 10'd100 + {1'b0, hole[1:0], 7'd0};
  endfunction

  function automatic logic [9:0] y_of(input logic [2:0] hole);
    return hole[2] ? 10'd210 : 10'd50;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  state_t               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [NUM_HOLES-1:0] hit_btn_q, hit_btn_d;
  logic [2:0]           hole_q, hole_d;
  logic [9:0]           x_off_q, x_off_d;
  logic [9:0]           y_off_q, y_off_d;
  logic [7:0]           score_q, score_d;
  logic [7:0]           misses_q, misses_d;
  logic                 visible_q, visible_d;
  logic                 over_q, over_d;

  logic [NUM_HOLES-1:0] btn_edge;
  logic                 hit_now;
  logic                 tick;
  logic                 gap_done;
  logic                 up_done;
  logic [7:0]           miss_cnt;

  assign btn_edge = hit_btn & ~hit_btn_q;
  assign hit_now  = |(btn_edge & (HOLE0_SEL << hole_q));
  assign tick     = (presc_q == PRESC_LAST);
  assign gap_done = tick && (tick_cnt_q == GAP_LAST);
  assign up_done  = tick && (tick_cnt_q == UP_LAST);
  assign miss_cnt = misses_q + 8'd1;

  // Game state transitions together with score, miss and hole updates.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    misses_d = misses_q;
    hole_d   = hole_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d  = ST_GAP;
          score_d  = 8'd0;
          misses_d = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_d = ST_UP;
          hole_d  = pick_hole(lfsr_q, hole_q);
        end else begin
          state_d = state_q;
        end
      end
      ST_UP: begin
        // A hit on the very cycle the timer expires still counts as a hit.
        if (hit_now) begin
          state_d = ST_GAP;
          score_d = sat_inc(score_q);
        end else if (up_done) begin
          misses_d = miss_cnt;
          if (miss_cnt == MISS_LIMIT) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Phase timer: restarts on every state change, idles outside GAP/UP.
  always_comb begin
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    if (state_d != state_q) begin
      presc_d    = '0;
      tick_cnt_d = '0;
    end else if ((state_q == ST_GAP) || (state_q == ST_UP)) begin
      if (tick) begin
        presc_d    = '0;
        tick_cnt_d = tick_cnt_q + TW'(1);
      end else begin
        presc_d    = presc_q + PW'(1);
        tick_cnt_d = tick_cnt_q;
      end
    end else begin
      presc_d    = '0;
      tick_cnt_d = '0;
    end
  end

  // Free-running LFSR, button history and next output values.
  always_comb begin
    lfsr_d    = lfsr_next(lfsr_q);
    hit_btn_d = hit_btn;
    visible_d = (state_d == ST_UP);
    over_d    = (state_d == ST_OVER);
    // Offsets follow the next hole so hole and offsets change on one edge.
    x_off_d   = x_of(hole_d);
    y_off_d   = y_of(hole_d);
  end

  // Control state, timers, LFSR and button history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      lfsr_q     <= LFSR_SEED;
      hit_btn_q  <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      lfsr_q     <= lfsr_d;
      hit_btn_q  <= hit_btn_d;
    end
  end

  // Registered outputs seen by the renderer and score display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hole_q    <= 3'd0;
      x_off_q   <= 10'd100;
      y_off_q   <= 10'd50;
      score_q   <= 8'd0;
      misses_q  <= 8'd0;
      visible_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      hole_q    <= hole_d;
      x_off_q   <= x_off_d;
      y_off_q   <= y_off_d;
      score_q   <= score_d;
      misses_q  <= misses_d;
      visible_q <= visible_d;
      over_q    <= over_d;
    end
  end

  assign mole_visible    = visible_q;
  assign mole_hole       = hole_q;
  assign sprite_x_offset = x_off_q;
  assign sprite_y_offset = y_off_q;
  assign score           = score_q;
  assign misses          = misses_q;
  assign game_over       = over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: table-driven and randomized bench for mole_scheduler.
// A phase-level reference model (cycles left in the current phase, hole
// picked by arithmetic on the LFSR value) runs alongside the DUT and every
// output is compared one time unit after each rising edge.
module tb_mole_scheduler;
  localparam int NH = 4;
  localparam int TD = 4;
  localparam int UT = 3;
  localparam int GT = 2;
  localparam int MM = 3;

  localparam int S_IDLE = 0;
  localparam int S_GAP  = 1;
  localparam int S_UP   = 2;
  localparam int S_OVER = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NH-1:0] hit_btn;
  logic          mole_visible;
  logic [2:0]    mole_hole;
  logic [9:0]    sprite_x_offset;
  logic [9:0]    sprite_y_offset;
  logic [7:0]    score;
  logic [7:0]    misses;
  logic          game_over;

  mole_scheduler #(
    .NUM_HOLES(NH), .TICK_DIV(TD), .UP_TICKS(UT), .GAP_TICKS(GT), .MAX_MISSES(MM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hit_btn(hit_btn),
    .mole_visible(mole_visible), .mole_hole(mole_hole),
    .sprite_x_offset(sprite_x_offset), .sprite_y_offset(sprite_y_offset),
    .score(score), .misses(misses), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int            m_state;
  int            m_left;
  int            m_hole;
  int            m_score;
  int            m_misses;
  logic [7:0]    m_lfsr;
  logic [NH-1:0] m_prev_btn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state    = S_IDLE;
    m_left     = 0;
    m_hole     = 0;
    m_score    = 0;
    m_misses   = 0;
    m_lfsr     = 8'hA5;
    m_prev_btn = '0;
  endtask

  // One clock edge of the game rules, using the inputs present before the edge.
  task automatic model_edge();
    logic [NH-1:0] edges;
    int cand;
    edges = hit_btn & ~m_prev_btn;
    case (m_state)
      S_IDLE, S_OVER: begin
        if (start) begin
          m_state  = S_GAP;
          m_left   = GT * TD;
          m_score  = 0;
          m_misses = 0;
        end
      end
      S_GAP: begin
        m_left--;
        if (m_left == 0) begin
          cand = int'(m_lfsr) % NH;
          if (cand == m_hole) cand = (cand + 1) % NH;
          m_hole  = cand;
          m_state = S_UP;
          m_left  = UT * TD;
        end
      end
      S_UP: begin
        if (edges[m_hole]) begin
          if (m_score < 255) m_score++;
          m_state = S_GAP;
          m_left  = GT * TD;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_misses++;
            if (m_misses == MM) begin
              m_state = S_OVER;
            end else begin
              m_state = S_GAP;
              m_left  = GT * TD;
            end
          end
        end
      end
      default: m_state = S_IDLE;
    endcase
    m_lfsr     = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    m_prev_btn = hit_btn;
  endtask

  task automatic compare_all();
    check("visible", mole_visible, (m_state == S_UP) ? 1 : 0);
    check("hole", mole_hole, m_hole);
    check("x_off", sprite_x_offset, 100 + (m_hole % 4) * 128);
    check("y_off", sprite_y_offset, 50 + (m_hole / 4) * 160);
    check("score", score, m_score);
    check("misses", misses, m_misses);
    check("game_over", game_over, (m_state == S_OVER) ? 1 : 0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wait_up();
    for (int i = 0; i < 40 && m_state != S_UP; i++) step();
    check("wait_up_visible", mole_visible, 1);
  endtask

  typedef struct {
    logic          start;
    logic [NH-1:0] btn;
    int            reps;
    logic          vis;
    int            score;
    int            misses;
    logic          go;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int m0;
    int appear;
    int last_hole;
    int prev_state;
    logic seen_up;

    // First game: three untouched moles then a restart from OVER.
    vecs[0] = '{1'b1, 4'h0, 1,  1'b0, 0, 0, 1'b0};
    vecs[1] = '{1'b0, 4'h0, 7,  1'b0, 0, 0, 1'b0};
    vecs[2] = '{1'b0, 4'h0, 12, 1'b1, 0, 0, 1'b0};
    vecs[3] = '{1'b0, 4'h0, 8,  1'b0, 0, 1, 1'b0};
    vecs[4] = '{1'b0, 4'h0, 12, 1'b1, 0, 1, 1'b0};
    vecs[5] = '{1'b0, 4'h0, 8,  1'b0, 0, 2, 1'b0};
    vecs[6] = '{1'b0, 4'h0, 12, 1'b1, 0, 2, 1'b0};
    vecs[7] = '{1'b0, 4'h0, 3,  1'b0, 0, 3, 1'b1};
    vecs[8] = '{1'b1, 4'h0, 1,  1'b0, 0, 0, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    hit_btn = '0;
    model_reset();
    #12;
    check("rst_visible", mole_visible, 0);
    check("rst_hole", mole_hole, 0);
    check("rst_x", sprite_x_offset, 100);
    check("rst_y", sprite_y_offset, 50);
    check("rst_score", score, 0);
    check("rst_misses", misses, 0);
    check("rst_game_over", game_over, 0);
    rst = 1'b0;

    seen_up = 1'b0;
    foreach (vecs[k]) begin
      start   = vecs[k].start;
      hit_btn = vecs[k].btn;
      for (int r = 0; r < vecs[k].reps; r++) begin
        step();
        start = 1'b0;
        check("tbl_visible", mole_visible, vecs[k].vis);
        check("tbl_score", score, vecs[k].score);
        check("tbl_misses", misses, vecs[k].misses);
        check("tbl_game_over", game_over, vecs[k].go);
        if (mole_visible && !seen_up) begin
          seen_up = 1'b1;
          check("first_hole_nonzero", (mole_hole != 3'd0) ? 1 : 0, 1);
        end
      end
    end

    // Wrong button ignored, then the correct one scores.
    wait_up();
    s0 = m_score;
    hit_btn = NH'(1) << ((m_hole + 1) % NH);
    step();
    check("wrong_btn_visible", mole_visible, 1);
    check("wrong_btn_score", score, s0);
    hit_btn = '0;
    step();
    hit_btn = NH'(1) << m_hole;
    step();
    check("hit_visible", mole_visible, 0);
    check("hit_score", score, s0 + 1);
    hit_btn = '0;

    // Hit lands on the exact timeout edge: the hit wins.
    wait_up();
    s0 = m_score;
    m0 = m_misses;
    for (int i = 0; i < UT * TD - 1; i++) step();
    check("pre_timeout_visible", mole_visible, 1);
    hit_btn = NH'(1) << m_hole;
    step();
    check("tie_visible", mole_visible, 0);
    check("tie_score", score, s0 + 1);
    check("tie_misses", misses, m0);
    hit_btn = '0;

    // Buttons held across GAP->UP do not score until re-pressed.
    hit_btn = '1;
    wait_up();
    s0 = m_score;
    for (int i = 0; i < 3; i++) step();
    check("held_score", score, s0);
    check("held_visible", mole_visible, 1);
    hit_btn = '0;
    step();
    hit_btn = NH'(1) << m_hole;
    step();
    check("repress_score", score, s0 + 1);
    check("repress_visible", mole_visible, 0);
    hit_btn = '0;

    // Asynchronous reset in the middle of UP.
    wait_up();
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    check("arst_visible", mole_visible, 0);
    check("arst_hole", mole_hole, 0);
    check("arst_x", sprite_x_offset, 100);
    check("arst_y", sprite_y_offset, 50);
    check("arst_score", score, 0);
    check("arst_misses", misses, 0);
    check("arst_game_over", game_over, 0);
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("idle_after_rst", mole_visible, 0);

    // Score saturation: 256 hits leave the score at 255.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int h = 0; h < 256; h++) begin
      wait_up();
      if (h == 255) check("pre_sat_score", score, 255);
      hit_btn = NH'(1) << m_hole;
      step();
      hit_btn = '0;
    end
    check("sat_score", score, 255);
    check("sat_misses", misses, 0);

    // Random play over at least 50 appearances.
    appear = 0;
    last_hole = -1;
    for (int c = 0; c < 8000 && appear < 50; c++) begin
      if ($urandom_range(0, 7) == 0) hit_btn = NH'($urandom_range(0, 15));
      start = ($urandom_range(0, 15) == 0);
      prev_state = m_state;
      step();
      if (prev_state != S_UP && m_state == S_UP) begin
        appear++;
        if (last_hole >= 0) check("hole_differs", (int'(mole_hole) != last_hole) ? 1 : 0, 1);
        check("rnd_x_pair", sprite_x_offset, 100 + (int'(mole_hole) % 4) * 128);
        check("rnd_y_pair", sprite_y_offset, 50 + (int'(mole_hole) / 4) * 160);
        last_hole = int'(mole_hole);
      end
    end
    check("appearances", appear, 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
